// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II JTAG debug command path:
// instruction codes, default register geometry and the sequencer state type.
package nios2_dbg_pkg;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACECTRL = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACEMEM  = 2'd3;

    localparam int DR_W_DEF    = 38;
    localparam int ACT_BIT_DEF = 34;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } seq_state_e;

endpackage

// File: rtl/nios2_dbg_toggle_sync.sv
// Brings a TCK-domain toggle into clk and flags each change against a baseline.
// While load_baseline is high the baseline just follows the synchroniser and no event is flagged.
module nios2_dbg_toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tgl,
    input  logic load_baseline,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   baseline;

    assign sync_out = sync[SYNC_STAGES-1];
    assign evt      = ~load_baseline & (sync_out ^ baseline);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= '0;
            baseline <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tgl};
            if (load_baseline || evt) begin
                baseline <= sync_out;
            end
        end
    end

endmodule

// File: rtl/nios2_debug_cmd_sequencer.sv
// System-clock command stage for the JTAG debug path: synchronises update-IR/DR
// toggles, captures {ir, dr} pairs into a FWFT buffer and hands them out valid/ready.
//
// state  | meaning
// SETTLE | synchronisers filling after reset; baselines load, events masked
// RUN    | toggle changes latch ir / push commands
module nios2_debug_cmd_sequencer
    import nios2_dbg_pkg::*;
#(
    parameter int IR_W        = 2,
    parameter int DR_W        = DR_W_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = ACT_BIT_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       uir_tgl,
    input  logic                       udr_tgl,
    input  logic [IR_W-1:0]            ir_in,
    input  logic [DR_W-1:0]            sr,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic [IR_W-1:0]            cmd_ir,
    output logic [DR_W-1:0]            cmd_data,
    output logic                       cmd_action,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int CNT_W = $clog2(SYNC_STAGES+1);
    localparam int ENT_W = IR_W + DR_W;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             settling;

    logic uir_evt, udr_evt;

    logic [IR_W-1:0]  ir_reg;
    logic [IR_W-1:0]  push_ir;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [ENT_W-1:0] head;
    logic [ENT_W-1:0] last_q;
    logic             full, push, pop, drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SETTLE;
            cnt_q   <= CNT_W'(SYNC_STAGES);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Down-counter runs SYNC_STAGES+1 cycles so the baselines see fully settled values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        settling = 1'b0;
        case (state_q)
            SETTLE: begin
                settling = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RUN: begin
                settling = 1'b0;
            end
            default: begin
                state_d  = SETTLE;
                settling = 1'b1;
            end
        endcase
    end

    nios2_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk           (clk),
        .reset         (reset),
        .tgl           (uir_tgl),
        .load_baseline (settling),
        .evt           (uir_evt)
    );

    nios2_dbg_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk           (clk),
        .reset         (reset),
        .tgl           (udr_tgl),
        .load_baseline (settling),
        .evt           (udr_evt)
    );

    // A same-cycle update-IR must reach the pushed command, so bypass ir_reg.
    assign push_ir = uir_evt ? ir_in : ir_reg;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign cmd_valid = (level_q != '0);
    assign pop       = cmd_valid & cmd_ready;
    assign push      = udr_evt & (~full | pop);
    assign drop      = udr_evt & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_reg  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            last_q  <= '0;
            ovf     <= 1'b0;
        end else begin
            if (uir_evt) begin
                ir_reg <= ir_in;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= head;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {push_ir, sr};
        end
    end

    // Empty buffer shows the last popped command rather than stale storage.
    assign head       = mem[rd_ptr];
    assign cmd_ir     = cmd_valid ? head[ENT_W-1 -: IR_W] : last_q[ENT_W-1 -: IR_W];
    assign cmd_data   = cmd_valid ? head[DR_W-1:0] : last_q[DR_W-1:0];
    assign cmd_action = cmd_data[ACT_BIT];
    assign level      = level_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sequencer.sv
// Directed bench for the debug command sequencer: a table of scan commands
// plus hand-written sequences for settle, overflow, pop/push overlap and reset.
module tb_nios2_debug_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        uir_tgl, udr_tgl;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic        cmd_action;
    logic [2:0]  level;
    logic        ovf, ovf_clr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic        same;
        logic [1:0]  exp_ir;
        logic [37:0] exp_data;
        logic        exp_act;
    } vec_t;

    vec_t vecs[4];
    logic [37:0] burst[6];

    nios2_debug_cmd_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .uir_tgl    (uir_tgl),
        .udr_tgl    (udr_tgl),
        .ir_in      (ir_in),
        .sr         (sr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ir     (cmd_ir),
        .cmd_data   (cmd_data),
        .cmd_action (cmd_action),
        .level      (level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_udr(input logic [37:0] d);
        sr      = d;
        udr_tgl = ~udr_tgl;
        repeat (4) tick();
    endtask

    task automatic pop_chk(input string name, input logic [37:0] exp);
        chk({name, "_valid"}, cmd_valid, 1);
        chk({name, "_data"}, cmd_data, exp);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ir: 2'd1, data: 38'h00_dead_beef, same: 1'b0,
                    exp_ir: 2'd1, exp_data: 38'h00_dead_beef, exp_act: 1'b0};
        vecs[1] = '{ir: 2'd3, data: 38'h3f_ffff_fffe, same: 1'b0,
                    exp_ir: 2'd3, exp_data: 38'h3f_ffff_fffe, exp_act: 1'b1};
        vecs[2] = '{ir: 2'd0, data: 38'h04_0000_0000, same: 1'b1,
                    exp_ir: 2'd0, exp_data: 38'h04_0000_0000, exp_act: 1'b1};
        vecs[3] = '{ir: 2'd2, data: 38'h3b_1234_5678, same: 1'b1,
                    exp_ir: 2'd2, exp_data: 38'h3b_1234_5678, exp_act: 1'b0};
        for (int i = 0; i < 6; i++) burst[i] = 38'h10_0000_0000 + 38'(i * 38'h111);

        // Reset with udr_tgl already high: no spurious command.
        reset = 1'b1; uir_tgl = 1'b0; udr_tgl = 1'b1; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) tick();
        chk("rst_level", level, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_ir", cmd_ir, 0);
        chk("rst_data", cmd_data, 0);
        chk("rst_ovf", ovf, 0);
        reset = 1'b0;
        repeat (20) tick();
        chk("settle_level", level, 0);
        chk("settle_valid", cmd_valid, 0);

        // Latency: cmd_valid rises exactly 3 cycles after the udr toggle.
        ir_in = 2'd2; uir_tgl = ~uir_tgl;
        repeat (5) tick();
        sr = 38'h04_0000_1234; udr_tgl = ~udr_tgl;
        tick(); tick();
        chk("lat_early_valid", cmd_valid, 0);
        tick();
        chk("lat_valid", cmd_valid, 1);
        chk("lat_ir", cmd_ir, 2);
        chk("lat_data", cmd_data, 38'h04_0000_1234);
        chk("lat_action", cmd_action, 1);
        chk("lat_level", level, 1);
        repeat (3) tick();
        chk("hold_data", cmd_data, 38'h04_0000_1234);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        chk("pop_level", level, 0);
        chk("pop_valid", cmd_valid, 0);
        chk("empty_hold_data", cmd_data, 38'h04_0000_1234);

        // Table of scan commands, some with same-cycle update-IR/DR.
        for (int i = 0; i < 4; i++) begin
            ir_in = vecs[i].ir;
            uir_tgl = ~uir_tgl;
            if (!vecs[i].same) repeat (5) tick();
            sr = vecs[i].data;
            udr_tgl = ~udr_tgl;
            repeat (3) tick();
            chk($sformatf("vec%0d_valid", i), cmd_valid, 1);
            chk($sformatf("vec%0d_ir", i), cmd_ir, vecs[i].exp_ir);
            chk($sformatf("vec%0d_data", i), cmd_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_act", i), cmd_action, vecs[i].exp_act);
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
            chk($sformatf("vec%0d_level", i), level, 0);
            repeat (2) tick();
        end

        // Five pushes into a 4-deep buffer: last one dropped.
        for (int i = 0; i < 5; i++) push_udr(burst[i]);
        chk("ovf_level", level, 4);
        chk("ovf_set", ovf, 1);
        for (int i = 0; i < 4; i++) pop_chk($sformatf("drain%0d", i), burst[i]);
        chk("drain_level", level, 0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_clr_alone", ovf, 0);

        // Full buffer, push lands in the same cycle as a pop.
        for (int i = 0; i < 4; i++) push_udr(burst[i] + 38'h1);
        chk("full_level", level, 4);
        chk("full_ovf", ovf, 0);
        sr = burst[4] + 38'h1; udr_tgl = ~udr_tgl;
        tick(); tick();
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        chk("pushpop_level", level, 4);
        chk("pushpop_ovf", ovf, 0);
        chk("pushpop_head", cmd_data, burst[1] + 38'h1);
        tick();

        // Drop and ovf_clr in the same cycle: set wins.
        sr = burst[5]; udr_tgl = ~udr_tgl;
        tick(); tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("setwins_ovf", ovf, 1);
        chk("setwins_level", level, 4);
        tick();
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("clr_after_drop", ovf, 0);

        // Reset with level 3 and a toggle in flight.
        pop_chk("pre_rst_pop", burst[1] + 38'h1);
        chk("pre_rst_level", level, 3);
        sr = 38'h2a_5555_aaaa; udr_tgl = ~udr_tgl;
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_level", level, 0);
        chk("midrst_valid", cmd_valid, 0);
        chk("midrst_data", cmd_data, 0);
        reset = 1'b0;
        repeat (20) tick();
        chk("post_rst_level", level, 0);
        chk("post_rst_valid", cmd_valid, 0);
        chk("post_rst_ovf", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
